// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder walks a WIDTH-bit operand pair LSB first,
// one bit per clock, with a registered carry and a one-cycle done pulse.

module fa_dataflow (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cr_q, cr_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_s, fa_c;
  logic             last_bit;
  logic [WIDTH-1:0] ps_shift;

  fa_dataflow u_fa (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .cin  (cr_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Each new sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
  generate
    if (WIDTH == 1) begin : g_ps1
      assign ps_shift = fa_s;
    end else begin : g_psn
      assign ps_shift = {fa_s, ps_q[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ps_d    = ps_q;
    cr_d    = cr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          sa_d    = a;
          sb_d    = b;
          cr_d    = cin;
          ps_d    = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        ps_d  = ps_shift;
        cr_d  = fa_c;
        cnt_d = cnt_q + 1'b1;
        // The result registers load only here, so partial shifts never show on sum.
        if (last_bit) begin
          state_d = S_DONE;
          sum_d   = ps_shift;
          cout_d  = fa_c;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      cr_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ps_q    <= ps_d;
      cr_q    <= cr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
